// File: rtl/ex_mem_buffer.sv
// rtl/ex_mem_buffer.sv - EX/MEM boundary stage: 2-entry skid buffer with flush and stall counter
// Head register drives MEM; skid register absorbs one beat while MEM back-pressures.
module ex_mem_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              mem_to_reg_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_to_reg_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int ENT_W = 2*DATA_W + REG_AW + 4;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ENT_W-1:0]   r_head;
    logic [ENT_W-1:0]   r_skid;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [ENT_W-1:0]   w_in_ent;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_load_head_in;
    logic               w_load_head_skid;
    logic               w_load_skid;
    logic               w_rw;
    logic               w_mr;
    logic               w_mw;
    logic               w_mtr;

    assign w_in_ent = {alu_result_i, rs2_data_i, rd_addr_i,
                       reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i};

    // Handshake signals come from registered state only, never from ready_i/valid_i.
    assign valid_o    = (r_state != S_EMPTY);
    assign ready_o    = (r_state != S_TWO);
    assign w_in_fire  = valid_i & ready_o;
    assign w_out_fire = valid_o & ready_i;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_load_head_in = 1'b1;
                    w_state_nxt    = S_ONE;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_head_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = S_TWO;
                end else if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_out_fire) begin
                    w_load_head_skid = 1'b1;
                    w_state_nxt      = S_ONE;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Flush overrides every handshake; the beat offered alongside it is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_head_in) begin
                r_head <= w_in_ent;
            end else if (w_load_head_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_ent;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (valid_o && !ready_i && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign {alu_result_o, rs2_data_o, rd_addr_o, w_rw, w_mr, w_mw, w_mtr} = r_head;

    // An empty buffer must never present a write or load to MEM.
    assign reg_write_o  = w_rw  & valid_o;
    assign mem_read_o   = w_mr  & valid_o;
    assign mem_write_o  = w_mw  & valid_o;
    assign mem_to_reg_o = w_mtr & valid_o;
    assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb/tb_ex_mem_buffer.sv - directed self-checking bench for ex_mem_buffer
module tb_ex_mem_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] alu_result_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] alu_result_o;
    logic [31:0] rs2_data_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;
    logic [15:0] stall_cnt_o;

    logic        s_ready_o, s_valid_o;
    logic [31:0] s_alu_result_o, s_rs2_data_o;
    logic [4:0]  s_rd_addr_o;
    logic        s_reg_write_o, s_mem_read_o, s_mem_write_o, s_mem_to_reg_o;
    logic [3:0]  s_stall_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ex_mem_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .alu_result_o(alu_result_o), .rs2_data_o(rs2_data_o), .rd_addr_o(rd_addr_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
        .stall_cnt_o(stall_cnt_o)
    );

    ex_mem_buffer #(.CNT_W(4)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(s_ready_o),
        .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
        .valid_o(s_valid_o), .ready_i(ready_i),
        .alu_result_o(s_alu_result_o), .rs2_data_o(s_rs2_data_o), .rd_addr_o(s_rd_addr_o),
        .reg_write_o(s_reg_write_o), .mem_read_o(s_mem_read_o),
        .mem_write_o(s_mem_write_o), .mem_to_reg_o(s_mem_to_reg_o),
        .stall_cnt_o(s_stall_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                         input logic rw, input logic mw);
        valid_i      = v;
        alu_result_i = alu;
        rs2_data_i   = ~alu;
        rd_addr_i    = rd;
        reg_write_i  = rw;
        mem_read_i   = 1'b0;
        mem_write_i  = mw;
        mem_to_reg_i = rw;
    endtask

    initial begin
        rst_i   = 1'b1;
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b1, 32'h99, 5'd9, 1'b1, 1'b1);

        // Reset held for two cycles with a beat offered
        tick();
        tick();
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_alu", alu_result_o, 0);
        check("rst_rs2", rs2_data_o, 0);
        check("rst_regw", reg_write_o, 0);
        check("rst_stall", stall_cnt_o, 0);
        rst_i = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        tick();
        check("rst_no_accept", valid_o, 0);

        // Streaming four back-to-back beats
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h10 * (k + 1), 5'(k + 1), 1'b1, 1'b0);
            tick();
            check($sformatf("strm_valid%0d", k), valid_o, 1);
            check($sformatf("strm_alu%0d", k), alu_result_o, 32'h10 * (k + 1));
            check($sformatf("strm_rd%0d", k), rd_addr_o, k + 1);
            check($sformatf("strm_ready%0d", k), ready_o, 1);
        end
        check("strm_rs2", rs2_data_o, 32'hFFFF_FFBF);
        drive(1'b0, 0, 0, 0, 0);
        tick();
        check("strm_drain", valid_o, 0);
        check("strm_stall", stall_cnt_o, 0);

        // Back-pressure into the skid register
        ready_i = 1'b0;
        drive(1'b1, 32'hA, 5'd10, 1'b0, 1'b0);
        tick();
        check("bp_ready1", ready_o, 1);
        drive(1'b1, 32'hB, 5'd11, 1'b0, 1'b0);
        tick();
        check("bp_ready2", ready_o, 0);
        drive(1'b0, 0, 0, 0, 0);
        repeat (4) tick();
        check("bp_stall5", stall_cnt_o, 5);
        check("bp_sat_stall5", s_stall_cnt_o, 5);
        check("bp_head", alu_result_o, 32'hA);
        ready_i = 1'b1;
        tick();
        check("bp_second", alu_result_o, 32'hB);
        check("bp_second_v", valid_o, 1);
        check("bp_ready_back", ready_o, 1);
        tick();
        check("bp_empty", valid_o, 0);
        check("bp_stall_hold", stall_cnt_o, 5);

        // Flush with two buffered stores and a beat offered
        ready_i = 1'b0;
        drive(1'b1, 32'h1, 5'd1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h2, 5'd2, 1'b0, 1'b1);
        tick();
        check("fl_full", ready_o, 0);
        check("fl_mw_pre", mem_write_o, 1);
        drive(1'b1, 32'hC, 5'd12, 1'b0, 1'b1);
        flush_i = 1'b1;
        tick();
        check("fl_valid", valid_o, 0);
        check("fl_mw", mem_write_o, 0);
        check("fl_ready", ready_o, 1);
        check("fl_alu_clr", alu_result_o, 0);
        check("fl_stall", stall_cnt_o, 7);
        // Flush while empty with an acceptable beat: beat must be discarded
        drive(1'b1, 32'hD, 5'd13, 1'b1, 1'b0);
        tick();
        check("fl_in_drop", valid_o, 0);
        flush_i = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        ready_i = 1'b1;
        repeat (2) tick();
        check("fl_no_c", valid_o, 0);

        // Control gating after drain
        drive(1'b1, 32'h55, 5'd5, 1'b1, 1'b0);
        tick();
        check("gt_regw_on", reg_write_o, 1);
        check("gt_m2r_on", mem_to_reg_o, 1);
        drive(1'b0, 0, 0, 0, 0);
        tick();
        check("gt_regw_off", reg_write_o, 0);
        check("gt_m2r_off", mem_to_reg_o, 0);
        check("gt_alu_keep", alu_result_o, 32'h55);

        // Saturation: 20 back-pressured cycles
        ready_i = 1'b0;
        drive(1'b1, 32'h77, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b0, 0, 0, 0, 0);
        repeat (20) tick();
        check("sat_small", s_stall_cnt_o, 15);
        check("sat_wide", stall_cnt_o, 27);

        // Reset mid-transfer drops the entry
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rst2_valid", valid_o, 0);
        check("rst2_mw", mem_write_o, 0);
        check("rst2_alu", alu_result_o, 0);
        check("rst2_stall", stall_cnt_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
